// File: rtl/matmul_apb_slave.sv
// APB register slave for a matrix-multiply core.
// It holds the control word and the A/B operand lines, and it forwards flag
// and scratchpad reads. Writes complete in the first ACCESS cycle. Reads take
// one extra RDWAIT cycle, which gives the scratchpad its one-cycle read latency.
module matmul_apb_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int BUS_WIDTH  = MAX_DIM * DATA_WIDTH,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [ADDR_WIDTH-1:0]          paddr_i,
  input  logic [BUS_WIDTH-1:0]           pwdata_i,
  input  logic [MAX_DIM-1:0]             pstrb_i,
  output logic [BUS_WIDTH-1:0]           prdata_o,
  output logic                           pready_o,
  output logic                           pslverr_o,
  input  logic                           busy_i,
  input  logic [BUS_WIDTH-1:0]           flags_i,
  output logic                           sp_rd_en_o,
  output logic [1:0]                     sp_rd_sel_o,
  output logic [$clog2(MAX_DIM)-1:0]     sp_rd_row_o,
  input  logic [BUS_WIDTH-1:0]           sp_rd_data_i,
  output logic                           start_o,
  output logic [15:0]                    ctrl_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]   operand_a_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]   operand_b_o
);

  localparam int ROW_W = $clog2(MAX_DIM);

  // Writable control bits: mode, write/read targets, n, k, m.
  // The start bit and the reserved bits are always stored as 0.
  localparam logic [15:0] CTRL_MASK = 16'h3F3E;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RDWAIT
  } state_e;

  // Register index taken from paddr_i[4:2].
  // Index 0 is CONTROL, 1 is OPERAND_A, 2 is OPERAND_B, 3 is FLAGS and 4-7 are SP0-SP3.
  localparam logic [2:0] R_CTRL  = 3'd0;
  localparam logic [2:0] R_OPA   = 3'd1;
  localparam logic [2:0] R_OPB   = 3'd2;
  localparam logic [2:0] R_FLAGS = 3'd3;

  state_e                             state_q;
  logic [15:0]                        ctrl_q;
  logic                               start_q;
  logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  opa_q;
  logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  opb_q;

  logic [2:0]       reg_sel;
  logic [ROW_W-1:0] line;
  logic             aligned;
  logic             wr_done;
  logic             rd_done;
  logic             wr_err;
  logic             commit;
  logic             unused_ok;

  assign reg_sel = paddr_i[4:2];
  assign line    = paddr_i[5 +: ROW_W];
  assign aligned = (paddr_i[1:0] == 2'b00);

  // The completing cycle is decoded from the live psel_i.
  // If psel_i drops mid-transfer, the cycle never completes, so no write commits.
  assign wr_done = (state_q == S_ACCESS) && psel_i && pwrite_i;
  assign rd_done = (state_q == S_RDWAIT) && psel_i;
  assign wr_err  = !aligned || (reg_sel >= R_FLAGS) || busy_i;
  assign commit  = wr_done && !wr_err;

  assign pready_o  = wr_done || rd_done;
  assign pslverr_o = (wr_done && wr_err) || (rd_done && !aligned);

  assign ctrl_o      = ctrl_q;
  assign start_o     = start_q;
  assign operand_a_o = opa_q;
  assign operand_b_o = opb_q;

  // Only some address and data bits are decoded.
  // The remaining bits and penable outside the setup check are intentionally ignored.
  assign unused_ok = ^{paddr_i, pwdata_i, penable_i};

  // Drive the scratchpad read request during the ACCESS cycle of an aligned SPx read.
  always_comb begin
    // NOTE: give every output a default first, so that no path through this block infers a latch.
    sp_rd_en_o  = 1'b0;
    sp_rd_sel_o = '0;
    sp_rd_row_o = '0;
    if ((state_q == S_ACCESS) && psel_i && !pwrite_i && aligned && reg_sel[2]) begin
      sp_rd_en_o  = 1'b1;
      sp_rd_sel_o = reg_sel[1:0];
      sp_rd_row_o = line;
    end
  end

  // Select read data. It is nonzero only in a read-completing cycle.
  always_comb begin
    prdata_o = '0;
    if (rd_done && aligned) begin
      case (reg_sel)
        R_CTRL:  prdata_o = BUS_WIDTH'(ctrl_q);
        R_OPA:   prdata_o = opa_q[line];
        R_OPB:   prdata_o = opb_q[line];
        R_FLAGS: prdata_o = flags_i;
        default: prdata_o = sp_rd_data_i;
      endcase
    end
  end

  // Transfer sequencing: IDLE, then ACCESS, then RDWAIT for reads only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples the values from before this edge.
      case (state_q)
        S_IDLE:   if (psel_i && !penable_i) state_q <= S_ACCESS;
        S_ACCESS: state_q <= (psel_i && !pwrite_i) ? S_RDWAIT : S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Commit register writes at the end of the pready cycle.
  // A committed start bit becomes a one-cycle start_o pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the operand lines are plain flops rather than a RAM, so they can be reset to zero directly.
      ctrl_q  <= '0;
      start_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      start_q <= commit && (reg_sel == R_CTRL) && pwdata_i[0];
      if (commit) begin
        case (reg_sel)
          R_CTRL: ctrl_q <= pwdata_i[15:0] & CTRL_MASK;
          R_OPA: begin
            for (int e = 0; e < MAX_DIM; e++)
              if (pstrb_i[e])
                opa_q[line][e*DATA_WIDTH +: DATA_WIDTH] <= pwdata_i[e*DATA_WIDTH +: DATA_WIDTH];
          end
          R_OPB: begin
            for (int e = 0; e < MAX_DIM; e++)
              if (pstrb_i[e])
                opb_q[line][e*DATA_WIDTH +: DATA_WIDTH] <= pwdata_i[e*DATA_WIDTH +: DATA_WIDTH];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed bench for matmul_apb_slave.
// Every expected value below is worked out by hand from the register map.
module tb_matmul_apb_slave;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         psel_i = 1'b0;
  logic         penable_i = 1'b0;
  logic         pwrite_i = 1'b0;
  logic [15:0]  paddr_i = '0;
  logic [31:0]  pwdata_i = '0;
  logic [3:0]   pstrb_i = '0;
  logic [31:0]  prdata_o;
  logic         pready_o;
  logic         pslverr_o;
  logic         busy_i = 1'b0;
  logic [31:0]  flags_i = 32'hCAFE_0042;
  logic         sp_rd_en_o;
  logic [1:0]   sp_rd_sel_o;
  logic [1:0]   sp_rd_row_o;
  logic [31:0]  sp_rd_data_i = 32'h1234_5678;
  logic         start_o;
  logic [15:0]  ctrl_o;
  logic [127:0] operand_a_o;
  logic [127:0] operand_b_o;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  matmul_apb_slave dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .psel_i       (psel_i),
    .penable_i    (penable_i),
    .pwrite_i     (pwrite_i),
    .paddr_i      (paddr_i),
    .pwdata_i     (pwdata_i),
    .pstrb_i      (pstrb_i),
    .prdata_o     (prdata_o),
    .pready_o     (pready_o),
    .pslverr_o    (pslverr_o),
    .busy_i       (busy_i),
    .flags_i      (flags_i),
    .sp_rd_en_o   (sp_rd_en_o),
    .sp_rd_sel_o  (sp_rd_sel_o),
    .sp_rd_row_o  (sp_rd_row_o),
    .sp_rd_data_i (sp_rd_data_i),
    .start_o      (start_o),
    .ctrl_o       (ctrl_o),
    .operand_a_o  (operand_a_o),
    .operand_b_o  (operand_b_o)
  );

  always #5 clk_i = ~clk_i;

  // Count every cycle in which start_o is high.
  always @(negedge clk_i) if (start_o) start_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer.
  // It is entered at posedge+1 and returns at posedge+1 of the completion edge, so calls can run back to back.
  // waits counts the ACCESS-phase cycles that pass before pready_o.
  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int waits, output logic err,
                          output logic [31:0] rdata, output logic sp_en,
                          output logic [1:0] sp_sel, output logic [1:0] sp_row);
    logic done;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = addr; pwdata_i = data; pstrb_i = strb;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    waits = 0; done = 1'b0; err = 1'b0; rdata = '0;
    @(negedge clk_i);
    sp_en = sp_rd_en_o; sp_sel = sp_rd_sel_o; sp_row = sp_rd_row_o;
    for (int i = 0; i < 4 && !done; i++) begin
      if (i > 0) @(negedge clk_i);
      if (pready_o) begin
        done = 1'b1; err = pslverr_o; rdata = prdata_o;
      end else begin
        waits++;
      end
    end
    check($sformatf("pready_seen@%h", addr), done, 1'b1);
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  int          w;
  logic        e, se;
  logic [1:0]  ss, sr;
  logic [31:0] rd;
  int          sc;

  initial begin
    repeat (3) @(posedge clk_i);
    // Reset state.
    @(negedge clk_i);
    check("rst_pready", pready_o, 0);
    check("rst_pslverr", pslverr_o, 0);
    check("rst_prdata", prdata_o, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_start", start_o, 0);
    check("rst_sp_en", sp_rd_en_o, 0);
    check("rst_opa_zero", operand_a_o == '0, 1);
    check("rst_opb_zero", operand_b_o == '0, 1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // penable without psel is ignored.
    penable_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("penable_only_pready", pready_o, 0);
    @(posedge clk_i); #1; penable_i = 1'b0;

    // OPERAND_A, line 2, full strobe. The address is 0x04 | (2 << 5) = 0x44.
    apb_xfer(1, 16'h0044, 32'h0403_0201, 4'b1111, w, e, rd, se, ss, sr);
    check("opa_wr_waits", w, 0);
    check("opa_wr_err", e, 0);
    check("opa_row2", operand_a_o[64 +: 32], 32'h0403_0201);
    @(negedge clk_i);
    check("pready_one_cycle", pready_o, 0);
    @(posedge clk_i); #1;

    // OPERAND_B, line 1, strobe 0101. The address is 0x08 | (1 << 5) = 0x28.
    apb_xfer(1, 16'h0028, 32'hAABB_CCDD, 4'b0101, w, e, rd, se, ss, sr);
    check("opb_wr_err", e, 0);
    check("opb_row1", operand_b_o[32 +: 32], 32'h00BB_00DD);
    apb_xfer(0, 16'h0028, 32'h0, 4'b0, w, e, rd, se, ss, sr);
    check("opb_rd_waits", w, 1);
    check("opb_rd_data", rd, 32'h00BB_00DD);
    check("opb_rd_err", e, 0);

    // CONTROL write with the start bit set.
    sc = start_cnt;
    apb_xfer(1, 16'h0000, 32'h0000_3B01, 4'b0000, w, e, rd, se, ss, sr);
    check("ctrl_wr_err", e, 0);
    check("start_after_commit", start_o, 1);
    check("ctrl_val", ctrl_o, 16'h3B00);
    repeat (3) @(posedge clk_i); #1;
    check("start_pulse_count", start_cnt - sc, 1);
    apb_xfer(0, 16'h0000, 32'h0, 4'b0, w, e, rd, se, ss, sr);
    check("ctrl_rd", rd, 32'h0000_3B00);

    // A busy core blocks writes to the operand and control registers.
    busy_i = 1'b1;
    apb_xfer(1, 16'h0004, 32'hFFFF_FFFF, 4'b1111, w, e, rd, se, ss, sr);
    check("busy_opa_err", e, 1);
    check("busy_opa_row0", operand_a_o[0 +: 32], 32'h0);
    sc = start_cnt;
    apb_xfer(1, 16'h0000, 32'h0000_0103, 4'b0000, w, e, rd, se, ss, sr);
    check("busy_ctrl_err", e, 1);
    check("busy_ctrl_val", ctrl_o, 16'h3B00);
    @(negedge clk_i);
    check("busy_ctrl_no_start", start_cnt - sc, 0);
    @(posedge clk_i); #1;
    busy_i = 1'b0;

    // FLAGS and SP writes are errors, and so is a misaligned write.
    apb_xfer(1, 16'h000C, 32'h1, 4'b1111, w, e, rd, se, ss, sr);
    check("flags_wr_err", e, 1);
    apb_xfer(1, 16'h0014, 32'h1, 4'b1111, w, e, rd, se, ss, sr);
    check("sp_wr_err", e, 1);
    apb_xfer(1, 16'h0006, 32'hFFFF_FFFF, 4'b1111, w, e, rd, se, ss, sr);
    check("misalign_wr_err", e, 1);
    check("misalign_opa_row0", operand_a_o[0 +: 32], 32'h0);

    // FLAGS read returns flags_i. A misaligned read returns an error.
    apb_xfer(0, 16'h000C, 32'h0, 4'b0, w, e, rd, se, ss, sr);
    check("flags_rd", rd, 32'hCAFE_0042);
    check("flags_rd_err", e, 0);
    apb_xfer(0, 16'h0045, 32'h0, 4'b0, w, e, rd, se, ss, sr);
    check("misalign_rd_err", e, 1);

    // SP2, line 3. The address is 0x18 | (3 << 5) = 0x78.
    apb_xfer(0, 16'h0078, 32'h0, 4'b0, w, e, rd, se, ss, sr);
    check("sp_rd_en", se, 1);
    check("sp_rd_sel", ss, 2);
    check("sp_rd_row", sr, 3);
    check("sp_rd_data", rd, 32'h1234_5678);
    check("sp_rd_err", e, 0);
    @(negedge clk_i);
    check("sp_rd_en_idle", sp_rd_en_o, 0);
    @(posedge clk_i); #1;

    // Two writes back to back. The high address bits are ignored.
    apb_xfer(1, 16'hF024, 32'h1111_1111, 4'b1111, w, e, rd, se, ss, sr);
    apb_xfer(1, 16'h0064, 32'h2222_2222, 4'b1111, w, e, rd, se, ss, sr);
    check("b2b_row1", operand_a_o[32 +: 32], 32'h1111_1111);
    check("b2b_row3", operand_a_o[96 +: 32], 32'h2222_2222);

    // Abort: psel drops during ACCESS, so no pready and no commit.
    psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = 16'h0004; pwdata_i = 32'hDEAD_BEEF; pstrb_i = 4'hF;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b1;
    @(negedge clk_i);
    check("abort_pready", pready_o, 0);
    @(posedge clk_i); #1; penable_i = 1'b0; pwrite_i = 1'b0;
    @(posedge clk_i); #1;
    check("abort_row0", operand_a_o[0 +: 32], 32'h0);

    // Reset during the ACCESS phase of a start write to CONTROL.
    sc = start_cnt;
    psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = 16'h0000; pwdata_i = 32'h1; pstrb_i = 4'h0;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_mid_pready", pready_o, 0);
    check("rst_mid_ctrl", ctrl_o, 0);
    check("rst_mid_opa_zero", operand_a_o == '0, 1);
    check("rst_mid_opb_zero", operand_b_o == '0, 1);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    check("rst_mid_no_start", start_cnt - sc, 0);
    check("rst_mid_ctrl_after", ctrl_o, 0);
    apb_xfer(1, 16'h0008, 32'h5566_7788, 4'b1111, w, e, rd, se, ss, sr);
    check("post_rst_err", e, 0);
    check("post_rst_opb_row0", operand_b_o[0 +: 32], 32'h5566_7788);

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time limit, so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "time limit");
  end

endmodule
